// File: rtl/lsu_ctrl_pkg.sv
// Shared load/store unit types and extension helpers for lsu_ctrl.
package lsu_ctrl_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    function automatic logic [XLEN-1:0] sext8(input logic [7:0] v);
        return {{(XLEN-8){v[7]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
        return {{(XLEN-16){v[15]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext8(input logic [7:0] v);
        return {{(XLEN-8){1'b0}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext16(input logic [15:0] v);
        return {{(XLEN-16){1'b0}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return {{(XLEN-32){1'b0}}, v};
    endfunction

endpackage

// File: rtl/lsu_ctrl_load_fmt.sv
// Load formatter: shifts the raw doubleword down to the accessed lane and
// sign/zero-extends it according to access size.
module lsu_load_fmt
    import lsu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [2:0]            off,
    input  logic [1:0]            size,
    input  logic                  is_unsigned,
    output logic [DATA_WIDTH-1:0] result
);

    logic [DATA_WIDTH-1:0] shifted_s;

    // Lane select followed by width truncation and extension
    always_comb begin
        shifted_s = rdata >> {off, 3'b000};
        result    = shifted_s;
        case (lsu_size_e'(size))
            BYTE: begin
                if (is_unsigned) result = DATA_WIDTH'(zext8(shifted_s[7:0]));
                else             result = DATA_WIDTH'(sext8(shifted_s[7:0]));
            end
            HALF: begin
                if (is_unsigned) result = DATA_WIDTH'(zext16(shifted_s[15:0]));
                else             result = DATA_WIDTH'(sext16(shifted_s[15:0]));
            end
            WORD: begin
                if (is_unsigned) result = DATA_WIDTH'(zext32(shifted_s[31:0]));
                else             result = DATA_WIDTH'(sext32(shifted_s[31:0]));
            end
            DOUBLE:  result = shifted_s;
            default: result = shifted_s;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller between core and memory.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned requests fault instead of aligning down.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [4:0]            req_rd,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [7:0]            mem_wstrb,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [4:0]            resp_rd,
    output logic                  resp_err,
    output logic                  busy
);

    lsu_state_e            state_r;
    logic [2:0]            off_r;
    logic [1:0]            size_r;
    logic                  uns_r;
    logic [2:0]            off_s;
    logic [7:0]            strb_s;
    logic [DATA_WIDTH-1:0] wdata_s;
    logic [DATA_WIDTH-1:0] fmt_s;
    logic                  trap_s;

    // Size-aligned lane offset, strobes and lane-shifted store data
    always_comb begin
        off_s  = req_addr[2:0];
        strb_s = 8'h01;
        case (lsu_size_e'(req_size))
            BYTE:    begin off_s = req_addr[2:0];            strb_s = 8'h01; end
            HALF:    begin off_s = {req_addr[2:1], 1'b0};    strb_s = 8'h03; end
            WORD:    begin off_s = {req_addr[2], 2'b00};     strb_s = 8'h0F; end
            DOUBLE:  begin off_s = 3'b000;                   strb_s = 8'hFF; end
            default: begin off_s = req_addr[2:0];            strb_s = 8'h01; end
        endcase
        strb_s  = strb_s << off_s;
        wdata_s = req_wdata << {off_s, 3'b000};
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Alignment only drops bits when the address was misaligned
    assign trap_s = (off_s != req_addr[2:0]);
`else
    assign trap_s = 1'b0;
`endif

    lsu_load_fmt #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_fmt (
        .rdata       (mem_rdata),
        .off         (off_r),
        .size        (size_r),
        .is_unsigned (uns_r),
        .result      (fmt_s)
    );

    // Control FSM with all core- and memory-facing outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            req_ready     <= 1'b1;
            busy          <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wstrb     <= 8'h00;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_rd       <= 5'd0;
            resp_err      <= 1'b0;
            off_r         <= 3'b000;
            size_r        <= 2'b00;
            uns_r         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        mem_we    <= req_is_store;
                        mem_addr  <= {req_addr[ADDR_WIDTH-1:3], 3'b000};
                        mem_wdata <= wdata_s;
                        mem_wstrb <= strb_s;
                        off_r     <= off_s;
                        size_r    <= req_size;
                        uns_r     <= req_unsigned;
                        resp_rd   <= req_rd;
                        if (trap_s) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state_r    <= RESP;
                        end else begin
                            mem_req_valid <= 1'b1;
                            state_r       <= ISSUE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        // A completion coincident with the handshake is taken at once
                        if (mem_rsp_valid) begin
                            resp_valid <= 1'b1;
                            resp_rdata <= mem_we ? '0 : fmt_s;
                            state_r    <= RESP;
                        end else begin
                            state_r <= WAIT;
                        end
                    end else begin
                        state_r <= ISSUE;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= mem_we ? '0 : fmt_s;
                        state_r    <= RESP;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized
// transactions against an arithmetic reference model.
module tb_lsu_ctrl;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_is_store, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [63:0] mem_rdata;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_err, busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_rd(resp_rd), .resp_err(resp_err), .busy(busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access with memory stalls and response back-pressure
    task automatic do_txn(input bit st, input logic [1:0] sz, input bit uns,
                          input logic [63:0] addr, input logic [63:0] wd,
                          input logic [63:0] rdat, input logic [4:0] rd,
                          input int istall, input int rdly, input int rstall);
        logic [63:0] nb, al, off, maddr, ew, er, mask;
        logic [7:0]  es;
        bit          mis;
        nb    = 64'd1 << sz;
        mis   = (addr % nb) != 64'd0;
        al    = addr - (addr % nb);
        off   = al % 64'd8;
        maddr = addr & ~64'h7;
        es    = 8'(((64'd1 << nb) - 64'd1) << off);
        ew    = wd << (off * 64'd8);
        mask  = (nb == 64'd8) ? ~64'd0 : ((64'd1 << (nb * 64'd8)) - 64'd1);
        er    = (rdat >> (off * 64'd8)) & mask;
        if (!uns && nb != 64'd8 && er[nb * 64'd8 - 64'd1]) er = er | ~mask;
        if (st || (TRAP && mis)) er = 64'd0;

        check_eq("idle_req_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_is_store = st; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; req_rd = rd;
        tick();
        req_valid = 1'b0;
        req_addr = {$urandom, $urandom};
        check_eq("busy_after_accept", 64'(busy), 64'd1);
        check_eq("ready_after_accept", 64'(req_ready), 64'd0);
        if (TRAP && mis) begin
            check_eq("trap_no_mem_req", 64'(mem_req_valid), 64'd0);
            check_eq("trap_err", 64'(resp_err), 64'd1);
        end else begin
            check_eq("mem_req_valid", 64'(mem_req_valid), 64'd1);
            check_eq("mem_addr", mem_addr, maddr);
            check_eq("mem_we", 64'(mem_we), 64'(st));
            if (st) begin
                check_eq("mem_wstrb", 64'(mem_wstrb), 64'(es));
                check_eq("mem_wdata", mem_wdata, ew);
            end
            for (int i = 0; i < istall; i++) begin
                mem_rsp_valid = 1'($urandom_range(0, 1));
                mem_rdata = {$urandom, $urandom};
                tick();
                mem_rsp_valid = 1'b0;
                check_eq("stall_mem_req_valid", 64'(mem_req_valid), 64'd1);
                check_eq("stall_mem_addr", mem_addr, maddr);
                check_eq("stall_no_resp", 64'(resp_valid), 64'd0);
            end
            mem_req_ready = 1'b1;
            if (rdly == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rdata = rdat;
            end
            tick();
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            mem_rdata = {$urandom, $urandom};
            if (rdly > 0) begin
                check_eq("wait_mem_req_dropped", 64'(mem_req_valid), 64'd0);
                check_eq("wait_no_resp", 64'(resp_valid), 64'd0);
                for (int i = 0; i < rdly - 1; i++) begin
                    tick();
                    check_eq("wait_no_resp", 64'(resp_valid), 64'd0);
                end
                mem_rsp_valid = 1'b1;
                mem_rdata = rdat;
                tick();
                mem_rsp_valid = 1'b0;
                mem_rdata = {$urandom, $urandom};
            end
            check_eq("resp_err", 64'(resp_err), 64'd0);
        end
        check_eq("resp_valid", 64'(resp_valid), 64'd1);
        check_eq("resp_rdata", resp_rdata, er);
        check_eq("resp_rd", 64'(resp_rd), 64'(rd));
        for (int i = 0; i < rstall; i++) begin
            tick();
            check_eq("hold_resp_valid", 64'(resp_valid), 64'd1);
            check_eq("hold_resp_rdata", resp_rdata, er);
            check_eq("hold_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check_eq("resp_done", 64'(resp_valid), 64'd0);
        check_eq("back_idle_ready", 64'(req_ready), 64'd1);
        check_eq("back_idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 64'd0; req_wdata = 64'd0; req_rd = 5'd0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 64'd0; resp_ready = 1'b0;
        #12;
        check_eq("rst_req_ready", 64'(req_ready), 64'd1);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("rst_mem_addr", mem_addr, 64'd0);
        #5 rst_n = 1'b1;
        tick();

        // LB / LBU at 0x1003
        do_txn(1'b0, 2'd0, 1'b0, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 5'd3, 0, 1, 0);
        check_eq("lb_sign", resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        do_txn(1'b0, 2'd0, 1'b1, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 5'd4, 0, 1, 0);
        check_eq("lbu_zero", resp_rdata, 64'h0000_0000_0000_0080);
        // SW at 0x2004
        do_txn(1'b1, 2'd2, 1'b0, 64'h2004, 64'h1234_5678, 64'hDEAD_BEEF_DEAD_BEEF, 5'd5, 0, 1, 0);
        // Memory back-pressure for 4 cycles
        do_txn(1'b0, 2'd3, 1'b0, 64'h0000_1000_0000_0010, 64'd0, 64'h0123_4567_89AB_CDEF, 5'd6, 4, 1, 0);
        // Misaligned LD at 0x3004
        do_txn(1'b0, 2'd3, 1'b0, 64'h3004, 64'd0, 64'h1111_2222_3333_4444, 5'd7, 0, 2, 1);

        // Reset during WAIT abandons the access
        req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'd2; req_addr = 64'h4000; req_rd = 5'd9;
        tick();
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 64'(busy), 64'd0);
        check_eq("arst_req_ready", 64'(req_ready), 64'd1);
        check_eq("arst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check_eq("arst_mem_addr", mem_addr, 64'd0);
        check_eq("arst_resp_rd", 64'(resp_rd), 64'd0);
        #2 rst_n = 1'b1;
        tick();
        mem_rsp_valid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        mem_rsp_valid = 1'b0;
        check_eq("late_rsp_ignored", 64'(resp_valid), 64'd0);
        check_eq("late_rsp_busy", 64'(busy), 64'd0);

        // New request pending while response is back-pressured
        req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 64'h4008; req_rd = 5'd7;
        tick();
        req_valid = 1'b0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 64'h89AB_CDEF_0123_4567;
        tick();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        check_eq("b2b_resp_valid", 64'(resp_valid), 64'd1);
        check_eq("b2b_resp_rdata", resp_rdata, 64'h0000_0000_0123_4567);
        req_valid = 1'b1; req_is_store = 1'b1; req_size = 2'd0; req_addr = 64'h5001;
        req_wdata = 64'hAB; req_rd = 5'd8;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("b2b_req_ready_low", 64'(req_ready), 64'd0);
            check_eq("b2b_no_issue", 64'(mem_req_valid), 64'd0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check_eq("b2b_resp_done", 64'(resp_valid), 64'd0);
        check_eq("b2b_not_yet_issued", 64'(mem_req_valid), 64'd0);
        tick();
        req_valid = 1'b0;
        check_eq("b2b_issue", 64'(mem_req_valid), 64'd1);
        check_eq("b2b_addr", mem_addr, 64'h5000);
        check_eq("b2b_wstrb", 64'(mem_wstrb), 64'h02);
        check_eq("b2b_wdata", mem_wdata, 64'hAB00);
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        check_eq("b2b_store_rdata", resp_rdata, 64'd0);
        check_eq("b2b_store_rd", 64'(resp_rd), 64'd8);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Randomized accesses
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                mem_rsp_valid = 1'b1; mem_rdata = {$urandom, $urandom};
                tick();
                mem_rsp_valid = 1'b0;
                check_eq("idle_rsp_ignored", 64'(resp_valid), 64'd0);
            end
            do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
